// File: rtl/rename_pkg.sv
// Shared sizing for the register-rename slice: architectural/physical register
// counts, index widths and free-list geometry.
package rename_pkg;

    localparam int NUM_PR   = 64;
    localparam int NUM_AR   = 32;
    localparam int PR_W     = 6;
    localparam int AR_W     = 5;
    localparam int FL_DEPTH = NUM_PR - NUM_AR;
    localparam int CNT_W    = 6;

endpackage : rename_pkg

// File: rtl/free_list.sv
// Circular free list of physical register numbers: two ordered pushes and one
// pop per cycle, with an occupancy count. Also holds its overflow checker.
module free_list
    import rename_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_push0,
    input  logic [PR_W-1:0] i_push0_pr,
    input  logic            i_push1,
    input  logic [PR_W-1:0] i_push1_pr,
    input  logic            i_pop,
    output logic [PR_W-1:0] o_head_pr,
    output logic [CNT_W-1:0] o_count,
    output logic            o_overflow
);

    logic [PR_W-1:0]  r_fifo [FL_DEPTH];
    logic [AR_W-1:0]  r_head;
    logic [AR_W-1:0]  r_tail;
    logic [CNT_W-1:0] r_count;

    logic [1:0]       w_n_push;
    logic [CNT_W:0]   w_count_next;
    logic [AR_W-1:0]  w_tail1;
    logic             w_overflow;

    assign w_n_push     = {1'b0, i_push0} + {1'b0, i_push1};
    assign w_count_next = {1'b0, r_count} + {{(CNT_W-1){1'b0}}, w_n_push}
                          - {{CNT_W{1'b0}}, i_pop};
    // A second push lands just behind the first when both are present.
    assign w_tail1      = r_tail + {{(AR_W-1){1'b0}}, i_push0};
    assign w_overflow   = (w_count_next > (CNT_W+1)'(FL_DEPTH));

    assign o_head_pr  = r_fifo[r_head];
    assign o_count    = r_count;
    assign o_overflow = w_overflow;

    // Free-list storage, pointers and count; an overflowing cycle leaves all unchanged.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_fifo[i] <= PR_W'(FL_DEPTH + i);
            end
            r_head  <= {AR_W{1'b0}};
            r_tail  <= {AR_W{1'b0}};
            r_count <= CNT_W'(FL_DEPTH);
        end else if (!w_overflow) begin
            if (i_push0) begin
                r_fifo[r_tail] <= i_push0_pr;
            end
            if (i_push1) begin
                r_fifo[w_tail1] <= i_push1_pr;
            end
            r_head  <= r_head + {{(AR_W-1){1'b0}}, i_pop};
            r_tail  <= r_tail + {{(AR_W-2){1'b0}}, w_n_push};
            r_count <= w_count_next[CNT_W-1:0];
        end else begin
            r_count <= r_count;
        end
    end

endmodule : free_list

module free_list_chk (
    input logic i_clk,
    input logic i_rst_n,
    input logic i_overflow
);

    // The ROB must never return more registers than the list can hold.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !i_overflow);

endmodule : free_list_chk

// File: rtl/register_rename.sv
// Register rename stage: arch->phys map table plus free list, with ROB retire
// and flush return paths. Optional FREE_LIST_BYPASS_EN forwards a retiring PR.
module register_rename
    import rename_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             isDispatch,
    input  logic             RegDest,
    input  logic [AR_W-1:0]  rs,
    input  logic [AR_W-1:0]  rt,
    input  logic [AR_W-1:0]  rd,
    input  logic             retire_reg,
    input  logic [PR_W-1:0]  PR_old_RT,
    input  logic             recover,
    input  logic [AR_W-1:0]  rd_flush,
    input  logic [PR_W-1:0]  PR_old_flush,
    input  logic [PR_W-1:0]  PR_new_flush,
    output logic [PR_W-1:0]  p_rs,
    output logic [PR_W-1:0]  p_rt,
    output logic [PR_W-1:0]  PR_old_DP,
    output logic [PR_W-1:0]  PR_new_DP,
    output logic [AR_W-1:0]  rd_DP,
    output logic             stall,
    output logic [CNT_W-1:0] free_count
);

    logic [PR_W-1:0]  r_map [NUM_AR];

    logic             w_req;
    logic             w_empty;
    logic             w_bypass;
    logic             w_alloc;
    logic             w_pop;
    logic             w_push_ret;
    logic [PR_W-1:0]  w_head_pr;
    logic [CNT_W-1:0] w_count;
    logic             w_overflow;

    assign w_req   = isDispatch & RegDest & (rd != {AR_W{1'b0}});
    assign w_empty = (w_count == {CNT_W{1'b0}});

`ifdef FREE_LIST_BYPASS_EN
    assign w_bypass = w_empty & retire_reg;
`else
    assign w_bypass = 1'b0;
`endif

    assign stall      = recover | (w_empty & w_req & ~w_bypass);
    assign w_alloc    = w_req & ~stall & ~recover;
    assign w_pop      = w_alloc & ~w_bypass;
    // A forwarded retiring PR is consumed directly and never enters the list.
    assign w_push_ret = retire_reg & ~(w_bypass & w_alloc);

    assign p_rs       = r_map[rs];
    assign p_rt       = r_map[rt];
    assign PR_old_DP  = r_map[rd];
    assign PR_new_DP  = w_bypass ? PR_old_RT : w_head_pr;
    assign rd_DP      = rd;
    assign free_count = w_count;

    // Map table: identity on reset, flush restore has priority over allocation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_AR; i++) begin
                r_map[i] <= PR_W'(i);
            end
        end else if (recover) begin
            r_map[rd_flush] <= PR_old_flush;
        end else if (w_alloc) begin
            r_map[rd] <= PR_new_DP;
        end else begin
            r_map[rd] <= r_map[rd];
        end
    end

    free_list u_free_list (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_push0    (recover),
        .i_push0_pr (PR_new_flush),
        .i_push1    (w_push_ret),
        .i_push1_pr (PR_old_RT),
        .i_pop      (w_pop),
        .o_head_pr  (w_head_pr),
        .o_count    (w_count),
        .o_overflow (w_overflow)
    );

    free_list_chk u_free_list_chk (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_overflow (w_overflow)
    );

endmodule : register_rename
